// File: rtl/pipe_pkg.sv
`default_nettype none
// pipe_pkg: shared constants and the IF/ID register layout for the fetch stage.
// Revision 1.0
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam int          CTRL_W_DEF     = 9;
  localparam int          CNT_W_DEF      = 16;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam int          IF_ID_W        = $bits(if_id_t);
  localparam logic [IF_ID_W-1:0] IF_ID_EMPTY = {32'h0000_0000, NOP_INSTR, 1'b0};

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// pipe_reg: W-bit register with sync reset, load enable and sync clear (flush).
// Revision 1.0
module pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // clear takes priority over load so a flush wins over a pending write
  always_ff @(posedge clk) begin
    if (rst)        r_q <= RST_VAL;
    else if (i_clr) r_q <= CLR_VAL;
    else if (i_en)  r_q <= i_d;
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/if_stage_pipe_ctrl.sv
`default_nettype none
// if_stage_pipe_ctrl: PC, IF/ID register and ID/EX bubble mux under hazard stall/flush control,
// with saturating stall/flush counters and a sticky stall-input consistency flag. Revision 1.0
module if_stage_pipe_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CTRL_W   = CTRL_W_DEF,
  parameter int          CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pcwrite,
  input  logic              if_id_write,
  input  logic              mux_bubble,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       instr_in,
  input  logic [CTRL_W-1:0] id_ctrl_in,
  output logic [31:0]       pc_out,
  output logic [31:0]       if_id_pc4,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic              protocol_err
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_d;
  logic        w_pc_en;
  if_id_t      w_if_id_d;
  if_id_t      w_if_id_q;
  logic        w_stall;
  logic        w_inconsistent;

  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;
  logic             r_protocol_err;

  assign w_pc_plus4 = next_pc(w_pc);
  // a taken branch redirects even when the hazard unit is holding the PC
  assign w_pc_en    = branch_taken | pcwrite;
  assign w_pc_d     = branch_taken ? branch_target : w_pc_plus4;

  pipe_reg #(
    .W       (32),
    .RST_VAL (RESET_PC),
    .CLR_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst   (reset),
    .i_en  (w_pc_en),
    .i_clr (1'b0),
    .i_d   (w_pc_d),
    .o_q   (w_pc)
  );

  assign w_if_id_d.pc4   = w_pc_plus4;
  assign w_if_id_d.instr = instr_in;
  assign w_if_id_d.valid = 1'b1;

  pipe_reg #(
    .W       (IF_ID_W),
    .RST_VAL (IF_ID_EMPTY),
    .CLR_VAL (IF_ID_EMPTY)
  ) u_if_id_reg (
    .clk   (clk),
    .rst   (reset),
    .i_en  (if_id_write),
    .i_clr (branch_taken),
    .i_d   (w_if_id_d),
    .o_q   (w_if_id_q)
  );

  assign w_stall        = ~branch_taken & ~pcwrite;
  assign w_inconsistent = ~branch_taken &
                          ({pcwrite, if_id_write, mux_bubble} != 3'b111) &
                          ({pcwrite, if_id_write, mux_bubble} != 3'b000);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count  <= '0;
      r_flush_count  <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      if (branch_taken && (r_flush_count != '1)) r_flush_count <= r_flush_count + c_cnt_one;
      if (w_stall && (r_stall_count != '1))      r_stall_count <= r_stall_count + c_cnt_one;
      if (w_inconsistent)                        r_protocol_err <= 1'b1;
    end
  end

  assign pc_out       = w_pc;
  assign if_id_pc4    = w_if_id_q.pc4;
  assign if_id_instr  = w_if_id_q.instr;
  assign if_id_valid  = w_if_id_q.valid;
  assign id_ex_ctrl   = (mux_bubble && w_if_id_q.valid) ? id_ctrl_in : '0;
  assign stall_count  = r_stall_count;
  assign flush_count  = r_flush_count;
  assign protocol_err = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_if_stage_pipe_ctrl.sv
`default_nettype none
// tb_if_stage_pipe_ctrl: directed + randomized stimulus, reference model feeds a scoreboard queue.
// Revision 1.0
module tb_if_stage_pipe_ctrl;

  localparam int          CTRL_W   = 9;
  localparam int          CNT_W    = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pcwrite = 1'b1;
  logic              if_id_write = 1'b1;
  logic              mux_bubble = 1'b1;
  logic              branch_taken = 1'b0;
  logic [31:0]       branch_target = 32'h0;
  logic [31:0]       instr_in = 32'h0;
  logic [CTRL_W-1:0] id_ctrl_in = '0;
  logic [31:0]       pc_out;
  logic [31:0]       if_id_pc4;
  logic [31:0]       if_id_instr;
  logic              if_id_valid;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;
  logic              protocol_err;

  if_stage_pipe_ctrl #(
    .RESET_PC (RESET_PC),
    .CTRL_W   (CTRL_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pcwrite       (pcwrite),
    .if_id_write   (if_id_write),
    .mux_bubble    (mux_bubble),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_in      (instr_in),
    .id_ctrl_in    (id_ctrl_in),
    .pc_out        (pc_out),
    .if_id_pc4     (if_id_pc4),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .id_ex_ctrl    (id_ex_ctrl),
    .stall_count   (stall_count),
    .flush_count   (flush_count),
    .protocol_err  (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       pc;
    logic [31:0]       pc4;
    logic [31:0]       instr;
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [CNT_W-1:0]  sc;
    logic [CNT_W-1:0]  fc;
    logic              err;
  } exp_t;

  exp_t scb[$];
  int checks = 0;
  int errors = 0;

  // reference state of the fetch stage, as the architecture describes it
  logic [31:0]      m_pc, m_pc4, m_instr;
  logic             m_valid, m_err;
  int               m_sc, m_fc;
  localparam int    CNT_MAX = (1 << CNT_W) - 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: every item pushed is compared at the following negedge
  always @(negedge clk) begin
    if (scb.size() > 0) begin
      exp_t e;
      e = scb.pop_front();
      chk("pc_out",       pc_out,                  e.pc);
      chk("if_id_pc4",    if_id_pc4,               e.pc4);
      chk("if_id_instr",  if_id_instr,             e.instr);
      chk("if_id_valid",  32'(if_id_valid),        32'(e.valid));
      chk("id_ex_ctrl",   32'(id_ex_ctrl),         32'(e.ctrl));
      chk("stall_count",  32'(stall_count),        32'(e.sc));
      chk("flush_count",  32'(flush_count),        32'(e.fc));
      chk("protocol_err", 32'(protocol_err),       32'(e.err));
    end
  end

  // apply the edge that just happened to the model, then present new inputs
  task automatic step(input logic rs, input logic pw, input logic iw, input logic mb,
                      input logic bt, input logic [31:0] tgt, input logic [31:0] ins,
                      input logic [CTRL_W-1:0] ct);
    exp_t e;
    @(posedge clk);
    #2;
    if (reset) begin
      m_pc = RESET_PC; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      m_sc = 0; m_fc = 0; m_err = 1'b0;
    end else if (branch_taken) begin
      m_pc = branch_target; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      if (m_fc < CNT_MAX) m_fc = m_fc + 1;
    end else begin
      if (if_id_write) begin
        m_instr = instr_in; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      if (pcwrite) m_pc = m_pc + 32'd4;
      else if (m_sc < CNT_MAX) m_sc = m_sc + 1;
      if (!((pcwrite && if_id_write && mux_bubble) || (!pcwrite && !if_id_write && !mux_bubble)))
        m_err = 1'b1;
    end
    reset = rs; pcwrite = pw; if_id_write = iw; mux_bubble = mb;
    branch_taken = bt; branch_target = tgt; instr_in = ins; id_ctrl_in = ct;
    e.pc = m_pc; e.pc4 = m_pc4; e.instr = m_instr; e.valid = m_valid;
    e.ctrl = (mb && m_valid) ? ct : '0;
    e.sc = CNT_W'(m_sc); e.fc = CNT_W'(m_fc); e.err = m_err;
    scb.push_back(e);
  endtask

  task automatic normal(input logic [31:0] ins, input logic [CTRL_W-1:0] ct);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, ins, ct);
  endtask

  initial begin
    logic [2:0]  trip;
    logic [31:0] tgt;
    int          r;

    // reset, then four fetches A..D
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 9'h1AB);
    normal(32'hAAAA_0001, 9'h011);
    normal(32'hBBBB_0002, 9'h022);
    normal(32'hCCCC_0003, 9'h033);
    normal(32'hDDDD_0004, 9'h044);
    // two-cycle hazard stall, then release
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hEEEE_0005, 9'h1FF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hEEEE_0005, 9'h1FF);
    normal(32'hEEEE_0005, 9'h055);
    // branch while stalled
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 9'h0F0);
    normal(32'h0000_0041, 9'h066);
    normal(32'h0000_0042, 9'h077);
    // inconsistent stall inputs: sticky error
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h5555_0000, 9'h100);
    repeat (3) normal(32'h6666_0000, 9'h101);
    // PC wrap at top of the address space
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0, 9'h0);
    normal(32'h7777_0001, 9'h003);
    normal(32'h7777_0002, 9'h004);
    // counter saturation (stall, then flush)
    repeat (CNT_MAX + 4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 9'h1);
    repeat (CNT_MAX + 4) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 9'h2);
    normal(32'h8888_0000, 9'h005);
    // reset together with branch and stall
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h9999_0000, 9'h006);
    normal(32'h9999_0001, 9'h007);
    normal(32'h9999_0002, 9'h008);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      trip = 3'b111;
      else if (r < 9) trip = 3'b000;
      else            trip = 3'($urandom);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step(($urandom_range(0, 99) == 0), trip[2], trip[1], trip[0],
           ($urandom_range(0, 7) == 0), tgt, $urandom, CTRL_W'($urandom));
    end

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (scb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", scb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
